// File: rtl/matrix_multiply_pkg.sv
// Shared constants for the 2x2 matrix multiply controller: byte counts,
// result width and controller state encoding.
package matrix_multiply_pkg;
  localparam int NUM_BYTES_FULL = 8;
  localparam int NUM_BYTES_A    = 4;
  localparam int RES_W          = 17;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
endpackage

// File: rtl/matrix_multiply_ctrl_if.sv
// Operand stream in, result stream out, job control; master is the host,
// slave is the controller.
interface matrix_multiply_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int RES_W  = matrix_multiply_pkg::RES_W
);
  import matrix_multiply_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              load_a_only;
  logic              abort;
  logic              out_valid;
  logic [RES_W-1:0]  out_data;
  logic [1:0]        out_idx;
  logic              out_ready;
  logic              done;

  modport master (
    output in_valid, in_data, load_a_only, abort, out_ready,
    input  in_ready, out_valid, out_data, out_idx, done
  );

  modport slave (
    input  in_valid, in_data, load_a_only, abort, out_ready,
    output in_ready, out_valid, out_data, out_idx, done
  );
endinterface

// File: rtl/matrix_multiply_ctrl.sv
// Sequences operand bytes into the matrix_multiply datapath and drains C00..C11.
// Last byte to out_valid: 2 edges; out_ready=0 holds the current element, abort cancels the job.
module matrix_multiply_ctrl #(
  parameter int DATA_W = 8,
  parameter int RES_W  = matrix_multiply_pkg::RES_W
) (
  input  logic                clk,
  input  logic                reset,
  matrix_multiply_ctrl_if.slave bus,
  output logic [2:0]          mm_sel_in,
  output logic [DATA_W-1:0]   mm_input_val,
  output logic                mm_execute,
  output logic [1:0]          mm_sel_out,
  input  logic [RES_W-1:0]    mm_result
);
  import matrix_multiply_pkg::*;

  logic [1:0]        state;
  logic [2:0]        cnt;
  logic              a_only;
  logic              wr_pend;
  logic [2:0]        wr_sel;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        out_idx;
  logic              done_q;

  logic accept;
  logic job_a_only;
  logic last_byte;
  logic drain;

  assign drain      = (state == ST_DRAIN);
  assign accept     = bus.in_valid & bus.in_ready;
  // Job mode comes from the live input on the first byte, from the latch afterwards.
  assign job_a_only = (cnt == 3'd0) ? bus.load_a_only : a_only;
  assign last_byte  = job_a_only ? (cnt == 3'(NUM_BYTES_A - 1))
                                 : (cnt == 3'(NUM_BYTES_FULL - 1));

  assign bus.in_ready  = (state == ST_LOAD) & ~bus.abort;
  assign bus.out_valid = drain;
  assign bus.out_data  = drain ? mm_result : '0;
  assign bus.out_idx   = out_idx;
  assign bus.done      = done_q;

  assign mm_sel_in    = wr_sel;
  assign mm_input_val = wr_data;
  assign mm_sel_out   = out_idx;
  // A write still pending when abort arrives must not land on the abort edge.
  assign mm_execute   = ~(wr_pend & ~bus.abort);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_LOAD;
      cnt     <= 3'd0;
      a_only  <= 1'b0;
      wr_pend <= 1'b0;
      wr_sel  <= 3'd0;
      wr_data <= '0;
      out_idx <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      wr_pend <= 1'b0;
      if (bus.abort) begin
        state   <= ST_LOAD;
        cnt     <= 3'd0;
        a_only  <= 1'b0;
        out_idx <= 2'd0;
      end else begin
        case (state)
          ST_LOAD: begin
            if (accept) begin
              wr_pend <= 1'b1;
              wr_sel  <= cnt;
              wr_data <= bus.in_data;
              if (cnt == 3'd0) a_only <= bus.load_a_only;
              if (last_byte) begin
                cnt   <= 3'd0;
                state <= ST_FLUSH;
              end else begin
                cnt <= cnt + 3'd1;
              end
            end
          end
          ST_FLUSH: begin
            state   <= ST_DRAIN;
            out_idx <= 2'd0;
          end
          ST_DRAIN: begin
            if (bus.out_ready) begin
              if (out_idx == 2'd3) begin
                state   <= ST_LOAD;
                out_idx <= 2'd0;
                done_q  <= 1'b1;
              end else begin
                out_idx <= out_idx + 2'd1;
              end
            end
          end
          default: state <= ST_LOAD;
        endcase
      end
    end
  end
endmodule

// File: doc/matrix_multiply_ctrl.md
MATRIX_MULTIPLY_CTRL -- requirements
Module: matrix_multiply_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, operand byte width.
REQ-002 Parameter RES_W, default 17, result width (2*DATA_W+1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand byte offered.
REQ-006 in_data  input  DATA_W  operand byte.
REQ-007 in_ready  output  1  controller accepts operand byte.
REQ-008 load_a_only  input  1  job mode, sampled on the first accepted byte of a job.
REQ-009 abort  input  1  synchronous job cancel.
REQ-010 out_valid  output  1  result element available.
REQ-011 out_data  output  RES_W  result element.
REQ-012 out_idx  output  2  element index: 0=C00, 1=C01, 2=C10, 3=C11.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 done  output  1  one-cycle pulse at job completion.
REQ-015 mm_sel_in  output  3  datapath register select.
REQ-016 mm_input_val  output  DATA_W  datapath write data.
REQ-017 mm_execute  output  1  datapath mode: 0 = write, 1 = compute/read.
REQ-018 mm_sel_out  output  2  datapath result select.
REQ-019 mm_result  input  RES_W  datapath result, combinational from mm_sel_out.

Function
REQ-020 The FSM SHALL have states LOAD, FLUSH and DRAIN; LOAD is the reset state.
REQ-021 in_ready SHALL be 1 only in LOAD with abort=0; a byte is accepted on an edge where in_valid&in_ready.
REQ-022 Byte order SHALL be A00, A01, A10, A11, B00, B01, B10, B11, mapped to mm_sel_in 0..7 by a 3-bit byte counter.
REQ-023 An accepted byte SHALL be registered into a write stage (wr_pend, wr_sel, wr_data); mm_sel_in=wr_sel and mm_input_val=wr_data.
REQ-024 mm_execute SHALL be !wr_pend, so the datapath is written exactly once per accepted byte, one edge after acceptance, and never otherwise.
REQ-025 With load_a_only=1 on the first byte, the job SHALL take 4 bytes (sel 0..3) and leave the B registers untouched; otherwise it takes 8 bytes.
REQ-026 Acceptance of the last byte SHALL move LOAD->FLUSH; FLUSH SHALL last one cycle (the final write lands), then move to DRAIN with out_idx=0.
REQ-027 out_valid SHALL rise on the second rising edge after the last input handshake.
REQ-028 In DRAIN: mm_sel_out=out_idx, out_valid=1, out_data=mm_result; outside DRAIN out_valid=0 and out_data=0.
REQ-029 out_idx SHALL increment on each out_valid&out_ready; out_data and out_idx SHALL hold stable while out_ready=0.
REQ-030 The handshake at out_idx=3 SHALL return the FSM to LOAD with the counter at 0 and pulse done for exactly one cycle.
REQ-031 Arithmetic belongs to the datapath; the controller SHALL pass RES_W bits unmodified, with no truncation.
REQ-032 abort=1 SHALL, on the next edge, force LOAD, clear the counter, out_idx and wr_pend, and cancel any pending write; abort has priority over all handshakes on that edge.
REQ-033 Bytes written to the datapath before an abort SHALL remain there; the next job overwrites them.

Reset
REQ-034 On reset=0: state=LOAD, counter=0, out_idx=0, wr_pend=0, done=0, out_valid=0, mm_execute=1, mm_sel_in=0, mm_input_val=0, mm_sel_out=0, in_ready=1 once reset is released.
REQ-035 Reset mid-job SHALL discard the job; no partial results are emitted afterwards.

Structure
REQ-036 The state encoding and the constants NUM_BYTES_FULL=8, NUM_BYTES_A=4 and RES_W SHALL live in the shared package matrix_multiply_pkg.
REQ-037 The block SHALL have no sub-modules; the parent instantiates matrix_multiply beside it and connects the mm_* ports.

Verification
REQ-038 Stream A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> outputs idx0..3 = 19, 22, 43, 50, then a done pulse.
REQ-039 All eight bytes 255 -> each output 130050, with no overflow at RES_W=17.
REQ-040 After REQ-038, a load_a_only job with A=[[1,0],[0,1]] -> outputs 5, 6, 7, 8 (B retained).
REQ-041 In DRAIN, hold out_ready=0 for 3 cycles -> out_data=19 and out_idx=0 stable; mm_execute stays 1 throughout.
REQ-042 Abort after 3 bytes, then a full REQ-038 job -> 19, 22, 43, 50; no write is observed on the abort edge.
REQ-043 Assert reset during DRAIN at out_idx=2 -> out_valid=0 immediately, then LOAD with in_ready=1 after release.
